// File: rtl/timer_bus_pkg.sv
// Shared types and default constants for the timer register-bus arbiter.
package timer_bus_pkg;

  localparam logic [7:0] ADDR_MAX_DEFAULT = 8'h07;
  localparam int         TIMEOUT_DEFAULT  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

endpackage

// File: rtl/timer_bus_arbiter_if.sv
// Requester-side register bus: a master raises req and holds it until the one-cycle ack.
interface timer_bus_arbiter_if;
  logic       req;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       err;

  modport master (output req, wr, addr, wdata, input ack, rdata, err);
  modport slave  (input req, wr, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/timer_rr_pick.sv
// Two-way round-robin selector: on a tie the requester that was not granted last wins.
module timer_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic       o_valid,
  output logic       o_winner
);

  assign o_valid  = |i_req;
  assign o_winner = (&i_req) ? ~i_last_gnt : i_req[1];

endmodule

// File: rtl/timer_bus_arbiter.sv
// Shares the timer register bus between two masters, one access at a time, with
// local rejection of out-of-range addresses and a timeout on a silent slave.
module timer_bus_arbiter
  import timer_bus_pkg::*;
#(
  parameter logic [7:0] ADDR_MAX = ADDR_MAX_DEFAULT,
  parameter int         TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  timer_bus_arbiter_if.slave        m0,
  timer_bus_arbiter_if.slave        m1,
  output logic                      o_t_sel,
  output logic                      o_t_wr,
  output logic [7:0]                o_t_addr,
  output logic [7:0]                o_t_wdata,
  input  logic [7:0]                i_t_rdata,
  input  logic                      i_t_ready
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_e           r_state;
  state_e           w_next_state;
  cmd_t             r_cmd;
  cmd_t             w_pick_cmd;
  logic             r_winner;
  logic             r_last_gnt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_valid;
  logic             w_winner;
  logic             w_addr_ok;
  logic             w_timeout;

  logic             w_t_sel;
  cmd_t             w_t_cmd;
  logic [1:0]       w_ack;
  logic             w_err;
  logic [7:0]       w_rdata;

  logic             r_t_sel;
  cmd_t             r_t_cmd;
  logic [1:0]       r_ack;
  logic [1:0]       r_err;
  logic [7:0]       r_rdata0;
  logic [7:0]       r_rdata1;

  timer_rr_pick u_pick (
    .i_req      ({m1.req, m0.req}),
    .i_last_gnt (r_last_gnt),
    .o_valid    (w_valid),
    .o_winner   (w_winner)
  );

  assign w_pick_cmd = w_winner ? cmd_t'{m1.wr, m1.addr, m1.wdata}
                               : cmd_t'{m0.wr, m0.addr, m0.wdata};
  assign w_addr_ok  = (w_pick_cmd.addr <= ADDR_MAX);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next_state = w_addr_ok ? ACCESS : DONE;
      ACCESS:  if (i_t_ready || w_timeout) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; ready wins over a same-cycle timeout.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_t_sel = 1'b0;
    w_t_cmd = '0;
    w_ack   = '0;
    w_err   = 1'b0;
    w_rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          if (w_addr_ok) begin
            w_t_sel = 1'b1;
            w_t_cmd = w_pick_cmd;
          end else begin
            w_ack[w_winner] = 1'b1;
            w_err           = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (i_t_ready) begin
          w_ack[r_winner] = 1'b1;
          w_rdata         = r_cmd.wr ? 8'h00 : i_t_rdata;
        end else if (w_timeout) begin
          w_ack[r_winner] = 1'b1;
          w_err           = 1'b1;
        end else begin
          w_t_sel = 1'b1;
          w_t_cmd = r_cmd;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= '0;
      r_winner   <= 1'b0;
      r_last_gnt <= 1'b1;
      r_cnt      <= '0;
      r_t_sel    <= 1'b0;
      r_t_cmd    <= '0;
      r_ack      <= '0;
      r_err      <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_t_sel  <= w_t_sel;
      r_t_cmd  <= w_t_cmd;
      r_ack    <= w_ack;
      r_err    <= w_ack & {2{w_err}};
      r_rdata0 <= w_ack[0] ? w_rdata : 8'h00;
      r_rdata1 <= w_ack[1] ? w_rdata : 8'h00;

      if (r_state == IDLE && w_valid) begin
        r_cmd    <= w_pick_cmd;
        r_winner <= w_winner;
      end

      // Counter saturates at the timeout value, so it can never wrap.
      if (r_state != ACCESS)            r_cnt <= '0;
      else if (!w_timeout)              r_cnt <= r_cnt + 1'b1;

      if (r_state == DONE) r_last_gnt <= r_winner;
    end
  end

  assign o_t_sel   = r_t_sel;
  assign o_t_wr    = r_t_cmd.wr;
  assign o_t_addr  = r_t_cmd.addr;
  assign o_t_wdata = r_t_cmd.wdata;

  assign m0.ack   = r_ack[0];
  assign m0.err   = r_err[0];
  assign m0.rdata = r_rdata0;
  assign m1.ack   = r_ack[1];
  assign m1.err   = r_err[1];
  assign m1.rdata = r_rdata1;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Self-checking bench: a transaction-level predictor plus a timer register model.
module tb_timer_bus_arbiter;

  localparam int         MAXC     = 1024;
  localparam int         TMO      = 16;
  localparam logic [7:0] ADDR_TOP = 8'h07;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_bus_arbiter_if m0 ();
  timer_bus_arbiter_if m1 ();

  logic       t_sel, t_wr, t_ready;
  logic [7:0] t_addr, t_wdata, t_rdata;

  timer_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0),
    .m1        (m1),
    .o_t_sel   (t_sel),
    .o_t_wr    (t_wr),
    .o_t_addr  (t_addr),
    .o_t_wdata (t_wdata),
    .i_t_rdata (t_rdata),
    .i_t_ready (t_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Timer register slave: ready after tm_delay wait cycles of t_sel (negative = never).
  int tm_delay;
  initial begin
    logic [7:0] tm_regs [8];
    int         tm_cnt;
    for (int i = 0; i < 8; i++) tm_regs[i] = 8'h10 + 8'(i);
    tm_cnt  = 0;
    t_ready = 1'b0;
    t_rdata = 8'h5A;
    forever begin
      @(posedge clk);
      #1;
      if (t_sel === 1'b1) begin
        if (tm_delay >= 0 && tm_cnt == tm_delay) begin
          t_ready = 1'b1;
          t_rdata = t_wr ? 8'hEE : tm_regs[t_addr[2:0]];
          if (t_wr) tm_regs[t_addr[2:0]] = t_wdata;
        end else begin
          t_ready = 1'b0;
          t_rdata = 8'h5A;
        end
        tm_cnt++;
      end else begin
        t_ready = 1'b0;
        t_rdata = 8'h5A;
        tm_cnt  = 0;
      end
    end
  end

  // Predictor: expected outputs per cycle, derived from accepted transactions.
  typedef struct packed {
    bit       sel;
    bit       wr;
    bit [7:0] addr;
    bit [7:0] wdata;
    bit       ack0;
    bit       ack1;
    bit       err;
    bit [7:0] rdata;
  } exp_t;

  exp_t e [MAXC];
  int   cyc = 0;

  task automatic post_ack(input int c, input bit who, input bit er, input bit [7:0] rd);
    if (c < MAXC) begin
      e[c].ack0  = !who;
      e[c].ack1  = who;
      e[c].err   = er;
      e[c].rdata = rd;
    end
  endtask

  initial begin
    bit [7:0] p_regs [8];
    int       free_at, len;
    bit       p_last, who, tmo, cwr;
    bit [7:0] caddr, cwdata, rd;
    for (int i = 0; i < 8; i++) p_regs[i] = 8'h10 + 8'(i);
    free_at = 0;
    p_last  = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        for (int c = cyc; c < MAXC; c++) e[c] = '0;
        free_at = cyc + 1;
        p_last  = 1'b1;
      end else if (cyc >= free_at && (m0.req || m1.req)) begin
        who    = (m0.req && m1.req) ? !p_last : m1.req;
        cwr    = who ? m1.wr    : m0.wr;
        caddr  = who ? m1.addr  : m0.addr;
        cwdata = who ? m1.wdata : m0.wdata;
        p_last = who;
        if (caddr > ADDR_TOP) begin
          post_ack(cyc, who, 1'b1, 8'h00);
          free_at = cyc + 2;
        end else begin
          tmo = (tm_delay < 0 || tm_delay >= TMO);
          len = tmo ? TMO : tm_delay + 1;
          for (int c = 0; c < len; c++) begin
            if (cyc + c < MAXC) begin
              e[cyc+c].sel   = 1'b1;
              e[cyc+c].wr    = cwr;
              e[cyc+c].addr  = caddr;
              e[cyc+c].wdata = cwdata;
            end
          end
          rd = (tmo || cwr) ? 8'h00 : p_regs[caddr[2:0]];
          if (!tmo && cwr) p_regs[caddr[2:0]] = cwdata;
          post_ack(cyc + len, who, tmo, rd);
          free_at = cyc + len + 2;
        end
      end
    end
  end

  // Compare process: every cycle on the falling edge.
  int sel_total = 0;
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (t_sel === 1'b1) sel_total++;
      if (cyc > 0 && cyc < MAXC) begin
        x = e[cyc];
        check("t_sel", 32'(t_sel), 32'(x.sel));
        if (x.sel) begin
          check("t_wr",    32'(t_wr),    32'(x.wr));
          check("t_addr",  32'(t_addr),  32'(x.addr));
          check("t_wdata", 32'(t_wdata), 32'(x.wdata));
        end
        check("m0_ack",   32'(m0.ack),   32'(x.ack0));
        check("m1_ack",   32'(m1.ack),   32'(x.ack1));
        check("m0_err",   32'(m0.err),   32'(x.ack0 & x.err));
        check("m1_err",   32'(m1.err),   32'(x.ack1 & x.err));
        check("m0_rdata", 32'(m0.rdata), 32'(x.ack0 ? x.rdata : 8'h00));
        check("m1_rdata", 32'(m1.rdata), 32'(x.ack1 ? x.rdata : 8'h00));
      end
    end
  end

  task automatic drive(input bit m, input bit req, input bit wr,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (m) begin
      m1.req = req; m1.wr = wr; m1.addr = addr; m1.wdata = wdata;
    end else begin
      m0.req = req; m0.wr = wr; m0.addr = addr; m0.wdata = wdata;
    end
  endtask

  // One access from master m; returns read data, err and edges from request to ack.
  task automatic access(input bit m, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rd,
                        output logic er, output int lat);
    bit got;
    got = 1'b0; rd = 8'h00; er = 1'b0; lat = 0;
    drive(m, 1'b1, wr, addr, wdata);
    repeat (40) begin
      @(posedge clk); #1;
      lat++;
      if ((m ? m1.ack : m0.ack) === 1'b1) begin
        got = 1'b1;
        rd  = m ? m1.rdata : m0.rdata;
        er  = m ? m1.err   : m0.err;
        break;
      end
    end
    drive(m, 1'b0, 1'b0, 8'h00, 8'h00);
    check("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat, s0, first, prev;
    int         order[$];
    int         times[$];

    rst = 1'b1;
    tm_delay = 0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_t_sel",   32'(t_sel),   32'd0);
    check("rst_t_addr",  32'(t_addr),  32'd0);
    check("rst_t_wdata", 32'(t_wdata), 32'd0);
    check("rst_t_wr",    32'(t_wr),    32'd0);

    // Write then read back through m0.
    s0 = sel_total;
    access(1'b0, 1'b1, 8'h01, 8'hA5, rd, er, lat);
    check("t1_wr_err", 32'(er), 32'd0);
    check("t1_wr_lat", 32'(lat), 32'd2);
    check("t1_wr_sel", 32'(sel_total - s0), 32'd1);
    access(1'b0, 1'b0, 8'h01, 8'h00, rd, er, lat);
    check("t1_rd_data", 32'(rd), 32'hA5);

    // m1 goes last so the following tie starts with m0.
    access(1'b1, 1'b0, 8'h01, 8'h00, rd, er, lat);
    check("t1_m1_rd", 32'(rd), 32'hA5);

    // Both masters request continuously.
    drive(1'b0, 1'b1, 1'b0, 8'h04, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h05, 8'h00);
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (m0.ack === 1'b1) begin order.push_back(0); times.push_back(i); end
      if (m1.ack === 1'b1) begin order.push_back(1); times.push_back(i); end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    check("t2_ack_count", 32'(order.size()), 32'd8);
    if (order.size() >= 4) begin
      check("t2_grant0", 32'(order[0]), 32'd0);
      check("t2_grant1", 32'(order[1]), 32'd1);
      check("t2_grant2", 32'(order[2]), 32'd0);
      check("t2_grant3", 32'(order[3]), 32'd1);
    end
    for (int i = 1; i < times.size(); i++)
      check("t2_spacing", 32'(times[i] - times[i-1]), 32'd3);

    // Out-of-range and top-of-range addresses.
    s0 = sel_total;
    access(1'b1, 1'b0, 8'h09, 8'h00, rd, er, lat);
    check("t3_err",   32'(er),  32'd1);
    check("t3_lat",   32'(lat), 32'd1);
    check("t3_rdata", 32'(rd),  32'd0);
    access(1'b1, 1'b1, 8'h08, 8'h33, rd, er, lat);
    check("t3_a8_err", 32'(er), 32'd1);
    check("t3_no_sel", 32'(sel_total - s0), 32'd0);
    access(1'b1, 1'b0, 8'h07, 8'h00, rd, er, lat);
    check("t3_a7_err",  32'(er), 32'd0);
    check("t3_a7_data", 32'(rd), 32'h17);

    // Timeout, then a normal access, then ready on the last allowed cycle.
    tm_delay = -1;
    s0 = sel_total;
    access(1'b0, 1'b0, 8'h02, 8'h00, rd, er, lat);
    check("t4_err",   32'(er),  32'd1);
    check("t4_rdata", 32'(rd),  32'd0);
    check("t4_lat",   32'(lat), 32'd17);
    check("t4_sel",   32'(sel_total - s0), 32'd16);
    tm_delay = 0;
    access(1'b1, 1'b0, 8'h02, 8'h00, rd, er, lat);
    check("t4_next_err",  32'(er), 32'd0);
    check("t4_next_data", 32'(rd), 32'h12);
    tm_delay = 15;
    access(1'b0, 1'b0, 8'h03, 8'h00, rd, er, lat);
    check("t4_late_err",  32'(er),  32'd0);
    check("t4_late_lat",  32'(lat), 32'd17);
    check("t4_late_data", 32'(rd),  32'h13);

    // Reset in the middle of an m1 write.
    tm_delay = -1;
    drive(1'b1, 1'b1, 1'b1, 8'h02, 8'h77);
    repeat (3) @(posedge clk);
    #1;
    check("t5_in_access", 32'(t_sel), 32'd1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_sel_low", 32'(t_sel),  32'd0);
    check("t5_no_ack0", 32'(m0.ack), 32'd0);
    check("t5_no_ack1", 32'(m1.ack), 32'd0);
    tm_delay = 0;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h06, 8'h00);
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      @(posedge clk); #1;
      if (m0.ack === 1'b1) first = 0;
      else if (m1.ack === 1'b1) first = 1;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("t5_tie_winner", 32'(first), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    access(1'b1, 1'b0, 8'h02, 8'h00, rd, er, lat);
    check("t5_write_dropped", 32'(rd), 32'h12);

    // m0 drops req mid-access; the ack still arrives with the data.
    access(1'b0, 1'b1, 8'h03, 8'h3C, rd, er, lat);
    tm_delay = 4;
    drive(1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    prev = 0;
    rd = 8'h00;
    for (int i = 0; i < 20 && prev == 0; i++) begin
      @(posedge clk); #1;
      if (m0.ack === 1'b1) begin prev = 1; rd = m0.rdata; er = m0.err; end
    end
    check("t6_ack_seen", 32'(prev), 32'd1);
    check("t6_rdata",    32'(rd),   32'h3C);
    check("t6_err",      32'(er),   32'd0);

    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
